// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage latch: state encoding,
// control-bundle reset fill and an occupancy helper.
package pipe_pkg;

  // Latch state: nothing held, main entry held, main plus skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } pipeState_t;

  // Fill bit for the control bundle on reset and bubbles (all zeros).
  localparam logic CTRL_RST_FILL = 1'b0;

  // Entries held in each state: EMPTY=0, FULL=1, SKID=2.
  function automatic logic [1:0] occupancyOf(input pipeState_t s);
    return {s[1], s[0] & ~s[1]};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One latch entry: valid flag plus control and data bundles.
// Reset zeroes everything; clear drops only the valid flag.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              dValid,
  input  logic [CTRL_W-1:0] dCtrl,
  input  logic [DATA_W-1:0] dData,
  output logic              qValid,
  output logic [CTRL_W-1:0] qCtrl,
  output logic [DATA_W-1:0] qData
);

  // Entry register: reset > clear > load; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      qValid <= 1'b0;
      qCtrl  <= {CTRL_W{CTRL_RST_FILL}};
      qData  <= '0;
    end else if (clear) begin
      qValid <= 1'b0;
    end else if (load) begin
      qValid <= dValid;
      qCtrl  <= dCtrl;
      qData  <= dData;
    end
  end

endmodule

// File: rtl/pipe_latch_skid.sv
// Parametrised inter-stage pipeline latch with valid/ready handshake,
// one-entry skid buffer, flush, bubble masking and a stall counter.
module pipe_latch_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W              = 16,
  parameter int CTRL_W              = 8,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1,
  parameter int CNT_W               = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipeState_t state, nextState;

  logic              mainValid, skidValid;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainData, skidData;

  logic              mainLoad, mainClear, mainFromSkid;
  logic              skidLoad, skidClear;
  logic [CTRL_W-1:0] mainCtrlIn;
  logic [DATA_W-1:0] mainDataIn;

  // Ready comes only from the skid register, never from out_ready.
  assign in_ready  = !skidValid;
  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign occupancy = occupancyOf(state);

  // Output control bundle, optionally masked to zero on bubbles.
  always_comb begin
    out_ctrl = mainCtrl;
    if (ZERO_CTRL_ON_BUBBLE && !mainValid)
      out_ctrl = {CTRL_W{CTRL_RST_FILL}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= nextState;
  end

  // Next state and entry load/clear controls; flush overrides all moves.
  always_comb begin
    nextState    = state;
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          mainLoad  = 1'b1;
          nextState = FULL;
        end
      end
      FULL: begin
        if (out_ready && in_valid) begin
          mainLoad = 1'b1;
        end else if (out_ready) begin
          mainClear = 1'b1;
          nextState = EMPTY;
        end else if (in_valid) begin
          skidLoad  = 1'b1;
          nextState = SKID;
        end
      end
      SKID: begin
        if (out_ready) begin
          mainLoad     = 1'b1;
          mainFromSkid = 1'b1;
          skidClear    = 1'b1;
          nextState    = FULL;
        end
      end
      default: begin
        mainClear = 1'b1;
        skidClear = 1'b1;
        nextState = EMPTY;
      end
    endcase
    if (flush) begin
      mainLoad  = 1'b0;
      skidLoad  = 1'b0;
      mainClear = 1'b1;
      skidClear = 1'b1;
      nextState = EMPTY;
    end
  end

  // Main entry source: the skid beat when draining, else the input.
  always_comb begin
    mainCtrlIn = in_ctrl;
    mainDataIn = in_data;
    if (mainFromSkid) begin
      mainCtrlIn = skidCtrl;
      mainDataIn = skidData;
    end
  end

  pipe_entry_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) uMain (
    .clk    (clk),
    .rst    (rst),
    .clear  (mainClear),
    .load   (mainLoad),
    .dValid (1'b1),
    .dCtrl  (mainCtrlIn),
    .dData  (mainDataIn),
    .qValid (mainValid),
    .qCtrl  (mainCtrl),
    .qData  (mainData)
  );

  pipe_entry_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) uSkid (
    .clk    (clk),
    .rst    (rst),
    .clear  (skidClear),
    .load   (skidLoad),
    .dValid (1'b1),
    .dCtrl  (in_ctrl),
    .dData  (in_data),
    .qValid (skidValid),
    .qCtrl  (skidCtrl),
    .qData  (skidData)
  );

  // Saturating count of stalled output cycles; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (mainValid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: directed scenarios plus random traffic,
// checked against a queue-based model of the latch.
module tb_pipe_latch_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
  logic [7:0]  stall_cnt;

  logic        in_ready4, out_valid4;
  logic [15:0] out_data4;
  logic [7:0]  out_ctrl4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int errCnt = 0;
  int chkCnt = 0;

  // Model: FIFO of held beats (max 2) and saturating stall counts.
  logic [15:0] mData[$];
  logic [7:0]  mCtrl[$];
  int          mCnt8 = 0;
  int          mCnt4 = 0;

  always #5 clk = ~clk;

  pipe_latch_skid #(
    .DATA_W(16), .CTRL_W(8), .ZERO_CTRL_ON_BUBBLE(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_latch_skid #(
    .DATA_W(16), .CTRL_W(8), .ZERO_CTRL_ON_BUBBLE(1'b1), .CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    int n;
    n = mData.size();
    checkVal("in_ready", in_ready, n < 2);
    checkVal("out_valid", out_valid, n > 0);
    checkVal("occupancy", occupancy, n);
    checkVal("stall_cnt", stall_cnt, mCnt8);
    checkVal("stall_cnt4", stall_cnt4, mCnt4);
    checkVal("occupancy4", occupancy4, n);
    if (n > 0) begin
      checkVal("out_data", out_data, mData[0]);
      checkVal("out_ctrl", out_ctrl, mCtrl[0]);
      checkVal("out_data4", out_data4, mData[0]);
    end else begin
      checkVal("out_ctrl_bubble", out_ctrl, 0);
      checkVal("out_ctrl4_bubble", out_ctrl4, 0);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic [15:0] d, input logic [7:0] c, input logic ordy);
    bit rdy, has;
    rst = r; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    if (r) begin
      mData.delete(); mCtrl.delete(); mCnt8 = 0; mCnt4 = 0;
    end else begin
      rdy = mData.size() < 2;
      has = mData.size() > 0;
      if (has && !ordy) begin
        if (mCnt8 < 255) mCnt8++;
        if (mCnt4 < 15)  mCnt4++;
      end
      if (has && ordy) begin
        void'(mData.pop_front());
        void'(mCtrl.pop_front());
      end
      if (iv && rdy) begin
        mData.push_back(d);
        mCtrl.push_back(c);
      end
      if (fl) begin
        mData.delete(); mCtrl.delete();
      end
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    // Reset with a beat and all-ones control on the input.
    step(1, 0, 1, 16'h1234, 8'hFF, 0);
    step(1, 0, 1, 16'h1234, 8'hFF, 0);
    checkVal("rst_out_valid", out_valid, 0);
    checkVal("rst_out_ctrl", out_ctrl, 8'h00);
    checkVal("rst_out_data", out_data, 16'h0000);
    checkVal("rst_in_ready", in_ready, 1);

    // Streaming with out_ready held high.
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 16'(i), 8'(i + 8'h10), 1);
      checkVal("stream_data", out_data, i);
      checkVal("stream_ready", in_ready, 1);
    end
    step(0, 0, 0, '0, '0, 1);
    checkVal("stream_drained", occupancy, 0);

    // Backpressure into the skid entry.
    step(0, 0, 1, 16'hA000, 8'h5A, 0);
    step(0, 0, 1, 16'hA001, 8'h5B, 0);
    checkVal("skid_occ", occupancy, 2);
    checkVal("skid_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'hDEAD, 8'h77, 0);
      checkVal("skid_hold_data", out_data, 16'hA000);
      checkVal("skid_hold_ctrl", out_ctrl, 8'h5A);
    end
    checkVal("skid_stall4", stall_cnt, 4);
    step(0, 0, 0, '0, '0, 1);
    checkVal("skid_drain1", out_data, 16'hA001);
    step(0, 0, 0, '0, '0, 1);
    checkVal("skid_drain_occ", occupancy, 0);

    // Flush while in SKID with a beat on the input.
    step(0, 0, 1, 16'hC000, 8'h11, 0);
    step(0, 0, 1, 16'hC001, 8'h12, 0);
    step(0, 1, 1, 16'hC002, 8'h13, 0);
    checkVal("flush_skid_valid", out_valid, 0);
    checkVal("flush_skid_ready", in_ready, 1);
    step(0, 0, 0, '0, '0, 1);
    checkVal("flush_no_reappear", out_valid, 0);

    // Flush during a delivery with an incoming beat.
    step(0, 0, 1, 16'hB000, 8'h21, 1);
    step(0, 1, 1, 16'hBEEF, 8'h22, 1);
    checkVal("flush_deliver_occ", occupancy, 0);
    step(0, 0, 0, '0, '0, 1);
    checkVal("flush_beef_gone", out_valid, 0);

    // Saturation of the narrow counter, then reset while in SKID.
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 1, 16'hE000, 8'h31, 0);
    step(0, 0, 1, 16'hE001, 8'h32, 0);
    for (int i = 0; i < 19; i++) step(0, 0, 0, '0, '0, 0);
    checkVal("sat_cnt4", stall_cnt4, 4'hF);
    checkVal("sat_cnt8", stall_cnt, 20);
    step(1, 0, 1, 16'hE002, 8'h33, 0);
    checkVal("rst_skid_occ", occupancy, 0);
    checkVal("rst_skid_cnt", stall_cnt, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
